score_unit: RTL and testbench
=============================

Name: score_unit

Overview:
- Upstream producer of the 24-bit score consumed by the level manager, which compares it against its score requirement at the exit tile.
- Accumulates item and enemy points, scaled by the current level.
- Runs a per-level countdown time bonus.
- On each level-complete pulse (hero_rst), tallies the remaining bonus into the score before the next level's countdown starts.

Parameters:
- TICK_DIV, 65_000_000, clk cycles per bonus-time decrement (1 s at 65 MHz).
- TALLY_DIV, 650_000, clk cycles per tally step.
- BONUS_START, 99, bonus_time value loaded at reset and after each tally.
- BONUS_PTS, 10, points added per tallied bonus unit.
- LIFE_STEP, 10000, score interval between extra lives (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pickup  in  1  one-cycle pulse, item or enemy collected.
- pickup_type  in  2  0=coin 10, 1=gem 50, 2=heart 100, 3=enemy 200 base points.
- level  in  4  current level from the level manager.
- hero_rst  in  1  one-cycle level-complete pulse from the level manager.
- score  out  24  accumulated score.
- bonus_time  out  8  remaining time bonus.
- busy  out  1  high while tallying.
- extra_life  out  1  one-cycle pulse (optional feature).

Behaviour:
- Reset (rst=0, async): score=0, bonus_time=BONUS_START, busy=0, extra_life=0, tick and tally counters=0, state=RUN.
- Points per pickup = base × (level+1), computed at 12 bits, max 200×16=3200.
- Score addition saturates at 24'hFFFFFF, no wrap.
- All outputs are registered. A pickup sampled at edge N shows in score after edge N; latency is 1 cycle.
- State RUN:
  - Tick counter increments each cycle.
  - At TICK_DIV-1 the tick counter returns to 0 and bonus_time decrements if >0. bonus_time holds at 0.
  - pickup adds its points.
  - hero_rst moves the state to TALLY and sets busy=1 at the next edge. The tally counter clears.
  - pickup and hero_rst in the same cycle: the pickup is credited, and TALLY is entered.
  - A tick expiry in the same cycle as hero_rst still decrements.
- State TALLY:
  - Tally counter increments each cycle. At TALLY_DIV-1 it returns to 0 and one step executes.
  - Step with bonus_time>0: bonus_time−1, score+=BONUS_PTS (saturating).
  - Step with bonus_time==0: bonus_time=BONUS_START, tick counter=0, busy=0, state=RUN.
  - pickup and hero_rst are ignored while in TALLY.
  - Tick counter frozen.
  - Entering with bonus_time already 0 costs exactly one TALLY_DIV period, then reload.
- Reset asserted mid-tally: immediate return to reset values; the partially tallied score is discarded (score=0).
- The level input is used only for pickup scaling; a level change during TALLY has no effect on tally.
- level=15 then 0 (wrap in the level manager): the multiplier follows the input, ×1.

Optional Feature:
- Macro SCORE_EXTRA_LIFE_EN.
- Defined:
  - Internal 24-bit next_life register, reset to LIFE_STEP.
  - When the registered score ≥ next_life, extra_life pulses for 1 cycle and next_life += LIFE_STEP (saturating at 24'hFFFFFF; no further pulses once saturated).
  - At most one pulse per cycle. A jump crossing several steps yields consecutive one-cycle pulses until caught up.
- Not defined: extra_life is tied to 0 and no next_life logic is built.

Test Plan:
- Reset, level=0, pickup_type=1 pulse → score=50 one cycle later; bonus_time=99, busy=0.
- level=3, pickup_type=3 pulse → score += 800; two pulses, types 0 and 2, on consecutive cycles → +40 then +400.
- TICK_DIV=4, idle 400+ cycles → bonus_time decrements every 4 cycles, 99→0, then stays 0.
- TALLY_DIV=2, bonus_time=5, score=1000:
  - Stimulus: hero_rst with a simultaneous pickup_type=0 at level=0.
  - Required: score=1010 and busy=1, then +10 every 2 cycles to 1060.
  - Then one more step reloads bonus_time=99 and busy=0.
  - Pickups during busy are not credited.
- Score preset near max via pickups (or a forced 24'hFFFF00), level=15, pickup_type=3 → score=24'hFFFFFF, no wrap; reset pulse mid-TALLY → score=0, busy=0, bonus_time=99 immediately.
- SCORE_EXTRA_LIFE_EN, LIFE_STEP=100:
  - Score 0→90→140 → one extra_life pulse at 140.
  - Then +200 (→340) → two consecutive pulses (thresholds 200, 300); next_life=400.
  - Macro undefined → extra_life constant 0.

Source files
------------

// File: rtl/score_unit.sv
// Score accumulator with level-scaled pickups, per-level countdown bonus and end-of-level tally.
// Optional extra-life pulses are built only when SCORE_EXTRA_LIFE_EN is defined.
`timescale 1ns/1ps

module score_unit #(
    parameter int TICK_DIV    = 65_000_000,
    parameter int TALLY_DIV   = 650_000,
    parameter int BONUS_START = 99,
    parameter int BONUS_PTS   = 10
`ifdef SCORE_EXTRA_LIFE_EN
    ,
    parameter int LIFE_STEP   = 10000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pickup,
    input  logic [1:0]  pickup_type,
    input  logic [3:0]  level,
    input  logic        hero_rst,
    output logic [23:0] score,
    output logic [7:0]  bonus_time,
    output logic        busy,
    output logic        extra_life
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TALLY_W = (TALLY_DIV > 1) ? $clog2(TALLY_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TALLY_W-1:0] TALLY_LAST = TALLY_W'(TALLY_DIV - 1);
    localparam logic [23:0] SCORE_MAX   = 24'hFFFFFF;
    localparam logic [7:0]  BONUS_INIT  = 8'(BONUS_START);
    localparam logic [11:0] BONUS_STEP  = 12'(BONUS_PTS);

    typedef enum logic {
        RUN,
        TALLY
    } state_t;

    state_t               r_state;
    logic [TICK_W-1:0]    r_tick;
    logic [TALLY_W-1:0]   r_tally;
    logic [7:0]           w_base;
    logic [11:0]          w_points;

    function automatic logic [23:0] satAdd(input logic [23:0] a, input logic [11:0] b);
        logic [24:0] sum;
        sum = {1'b0, a} + {13'b0, b};
        return sum[24] ? SCORE_MAX : sum[23:0];
    endfunction

    always_comb begin
        w_base = 8'd200;
        case (pickup_type)
            2'd0:    w_base = 8'd10;
            2'd1:    w_base = 8'd50;
            2'd2:    w_base = 8'd100;
            default: w_base = 8'd200;
        endcase
    end

    // Multiplier is level+1, so level 15 scales by 16 and the worst case is 3200.
    assign w_points = {4'b0, w_base} * {7'b0, ({1'b0, level} + 5'd1)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_tick     <= '0;
            r_tally    <= '0;
            score      <= '0;
            bonus_time <= BONUS_INIT;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (bonus_time != 8'd0) bonus_time <= bonus_time - 8'd1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                    if (pickup) score <= satAdd(score, w_points);
                    if (hero_rst) begin
                        r_state <= TALLY;
                        busy    <= 1'b1;
                        r_tally <= '0;
                    end
                end
                TALLY: begin
                    // The tick counter stays frozen here; the final empty step reloads it.
                    if (r_tally == TALLY_LAST) begin
                        r_tally <= '0;
                        if (bonus_time != 8'd0) begin
                            bonus_time <= bonus_time - 8'd1;
                            score      <= satAdd(score, BONUS_STEP);
                        end else begin
                            bonus_time <= BONUS_INIT;
                            r_tick     <= '0;
                            busy       <= 1'b0;
                            r_state    <= RUN;
                        end
                    end else begin
                        r_tally <= r_tally + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SCORE_EXTRA_LIFE_EN
    logic [23:0] r_nextLife;
    logic        r_lifeSat;
    logic [24:0] w_nextSum;

    assign w_nextSum = {1'b0, r_nextLife} + 25'(LIFE_STEP);

    // One pulse per cycle; a large jump is caught up over consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nextLife <= 24'(LIFE_STEP);
            r_lifeSat  <= 1'b0;
            extra_life <= 1'b0;
        end else if (!r_lifeSat && (score >= r_nextLife)) begin
            extra_life <= 1'b1;
            if (w_nextSum >= {1'b0, SCORE_MAX}) begin
                r_nextLife <= SCORE_MAX;
                r_lifeSat  <= 1'b1;
            end else begin
                r_nextLife <= w_nextSum[23:0];
            end
        end else begin
            extra_life <= 1'b0;
        end
    end
`else
    assign extra_life = 1'b0;
`endif

endmodule

// File: tb/tb_score_unit.sv
// Self-checking bench for score_unit: randomized and directed pickups/level-ends against a behavioural model.
// Extra-life expectations follow SCORE_EXTRA_LIFE_EN.
`timescale 1ns/1ps

module tb_score_unit;

    localparam int TICK_DIV    = 4;
    localparam int TALLY_DIV   = 2;
    localparam int BONUS_START = 99;
    localparam int BONUS_PTS   = 10;
    localparam longint SMAX    = 64'hFFFFFF;
`ifdef SCORE_EXTRA_LIFE_EN
    localparam int LIFE_STEP   = 100;
    localparam bit LIFE_ON     = 1'b1;
`else
    localparam bit LIFE_ON     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pickup;
    logic [1:0]  pickup_type;
    logic [3:0]  level;
    logic        hero_rst;
    logic [23:0] score;
    logic [7:0]  bonus_time;
    logic        busy;
    logic        extra_life;

    int testsRun = 0;
    int testsFailed = 0;

    // Model state: score, whether a tally is running, RUN cycles since the last reload,
    // bonus frozen at tally entry, and cycles spent in the current tally.
    longint m_score = 0;
    bit     m_inTally = 1'b0;
    int     m_runCyc = 0;
    int     m_bEntry = 0;
    int     m_tallyEdges = 0;
    bit     m_life = 1'b0;
    longint m_nextLife = 0;
    bit     m_lifeSat = 1'b0;
    longint prevScore = 0;

    score_unit #(
        .TICK_DIV(TICK_DIV),
        .TALLY_DIV(TALLY_DIV),
        .BONUS_START(BONUS_START),
        .BONUS_PTS(BONUS_PTS)
`ifdef SCORE_EXTRA_LIFE_EN
        ,
        .LIFE_STEP(LIFE_STEP)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .pickup(pickup),
        .pickup_type(pickup_type),
        .level(level),
        .hero_rst(hero_rst),
        .score(score),
        .bonus_time(bonus_time),
        .busy(busy),
        .extra_life(extra_life)
    );

    always #5 clk = ~clk;

    function automatic int basePts(input logic [1:0] t);
        case (t)
            2'd0:    return 10;
            2'd1:    return 50;
            2'd2:    return 100;
            default: return 200;
        endcase
    endfunction

    function automatic longint satScore(input longint v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    function automatic int runBonus(input int rc);
        int b;
        b = BONUS_START - rc / TICK_DIV;
        return (b < 0) ? 0 : b;
    endfunction

    function automatic int expBonus();
        if (m_inTally) return m_bEntry - m_tallyEdges / TALLY_DIV;
        return runBonus(m_runCyc);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pk, input logic [1:0] ty, input logic [3:0] lv, input logic hr);
        pickup      = pk;
        pickup_type = ty;
        level       = lv;
        hero_rst    = hr;
        @(posedge clk);
        #1;
        pickup   = 1'b0;
        hero_rst = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Behavioural model, updated on every active edge from the inputs seen at that edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_score      = 0;
                m_inTally    = 1'b0;
                m_runCyc     = 0;
                m_bEntry     = 0;
                m_tallyEdges = 0;
                m_life       = 1'b0;
                m_lifeSat    = 1'b0;
`ifdef SCORE_EXTRA_LIFE_EN
                m_nextLife   = LIFE_STEP;
`endif
            end else begin
                prevScore = m_score;
                if (!m_inTally) begin
                    m_runCyc++;
                    if (pickup) m_score = satScore(m_score + basePts(pickup_type) * (int'(level) + 1));
                    if (hero_rst) begin
                        m_inTally    = 1'b1;
                        m_tallyEdges = 0;
                        m_bEntry     = runBonus(m_runCyc);
                    end
                end else begin
                    m_tallyEdges++;
                    if (m_tallyEdges % TALLY_DIV == 0) begin
                        if (m_tallyEdges / TALLY_DIV <= m_bEntry) begin
                            m_score = satScore(m_score + BONUS_PTS);
                        end else begin
                            m_inTally = 1'b0;
                            m_runCyc  = 0;
                        end
                    end
                end
`ifdef SCORE_EXTRA_LIFE_EN
                if (!m_lifeSat && prevScore >= m_nextLife) begin
                    m_life     = 1'b1;
                    m_nextLife = m_nextLife + LIFE_STEP;
                    if (m_nextLife >= SMAX) begin
                        m_nextLife = SMAX;
                        m_lifeSat  = 1'b1;
                    end
                end else begin
                    m_life = 1'b0;
                end
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cyc score", score, m_score);
            checkOutput("cyc bonus_time", bonus_time, expBonus());
            checkOutput("cyc busy", busy, m_inTally);
            checkOutput("cyc extra_life", extra_life, m_life);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        pickup = 1'b0;
        pickup_type = 2'd0;
        level = 4'd0;
        hero_rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset score", score, 0);
        checkOutput("reset bonus", bonus_time, 99);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset extra_life", extra_life, 0);

        // Basic pickups and level scaling.
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 2'd1, 4'd0, 1'b0);
        @(negedge clk);
        checkOutput("gem lvl0 score", score, 50);
        checkOutput("gem lvl0 bonus", bonus_time, 99);
        checkOutput("gem lvl0 busy", busy, 0);
        applyStimulus(1'b1, 2'd3, 4'd3, 1'b0);
        @(negedge clk);
        checkOutput("enemy lvl3 score", score, 850);
        applyStimulus(1'b1, 2'd0, 4'd3, 1'b0);
        @(negedge clk);
        checkOutput("coin lvl3 score", score, 890);
        applyStimulus(1'b1, 2'd2, 4'd3, 1'b0);
        @(negedge clk);
        checkOutput("heart lvl3 score", score, 1290);
        checkOutput("first tick bonus", bonus_time, 98);

        // Countdown runs out and holds at zero.
        repeat (420) @(negedge clk);
        checkOutput("countdown floor", bonus_time, 0);

        // Random pickups with random level-end pulses.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
                          1'($urandom_range(0, 40) == 0));
        end
        repeat (500) @(negedge clk);

        // Tally with bonus 5: hero_rst lands on a tick expiry together with a coin pickup.
        pulseReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'd1, 4'd0, 1'b0);
        repeat (355) @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'd0, 4'd0, 1'b1);
        @(negedge clk);
        checkOutput("tally entry score", score, 1010);
        checkOutput("tally entry busy", busy, 1);
        checkOutput("tally entry bonus", bonus_time, 5);
        pickup = 1'b1;
        pickup_type = 2'd3;
        level = 4'd15;
        for (int k = 1; k <= 5; k++) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            checkOutput("tally step score", score, 1010 + 10 * k);
            checkOutput("tally step bonus", bonus_time, 5 - k);
            checkOutput("tally step busy", busy, 1);
        end
        pickup = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("tally reload bonus", bonus_time, 99);
        checkOutput("tally reload busy", busy, 0);
        checkOutput("tally reload score", score, 1060);

        // Extra-life thresholds (constant 0 when the feature is not built).
        pulseReset();
        applyStimulus(1'b1, 2'd0, 4'd8, 1'b0);
        @(negedge clk);
        checkOutput("life score 90", score, 90);
        checkOutput("life none at 90", extra_life, 0);
        applyStimulus(1'b1, 2'd1, 4'd0, 1'b0);
        @(negedge clk);
        checkOutput("life score 140", score, 140);
        @(negedge clk);
        checkOutput("life pulse 100", extra_life, LIFE_ON);
        @(negedge clk);
        checkOutput("life pulse end", extra_life, 0);
        applyStimulus(1'b1, 2'd2, 4'd1, 1'b0);
        @(negedge clk);
        checkOutput("life score 340", score, 340);
        @(negedge clk);
        checkOutput("life pulse 200", extra_life, LIFE_ON);
        @(negedge clk);
        checkOutput("life pulse 300", extra_life, LIFE_ON);
        @(negedge clk);
        checkOutput("life caught up", extra_life, 0);

        // Saturation at the top, then reset in the middle of a tally.
        pulseReset();
        pickup = 1'b1;
        pickup_type = 2'd3;
        level = 4'd15;
        for (int i = 0; i < 6000 && m_score != SMAX; i++) @(negedge clk);
        pickup = 1'b0;
        @(negedge clk);
        checkOutput("saturated score", score, 24'hFFFFFF);
        applyStimulus(1'b1, 2'd3, 4'd15, 1'b0);
        @(negedge clk);
        checkOutput("no wrap score", score, 24'hFFFFFF);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
        @(negedge clk);
        checkOutput("sat tally busy", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midtally rst score", score, 0);
        checkOutput("midtally rst busy", busy, 0);
        checkOutput("midtally rst bonus", bonus_time, 99);
        checkOutput("midtally rst life", extra_life, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
